// File: rtl/wrapper_arbiter_pkg.sv
// Shared types for the wrapper arbiter: FSM state encoding and service result codes.
package wrapper_arbiter_pkg;

  // FSM state encoding (2-bit, fixed values so checkers can decode dbg_state_o).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // Outcome of one service: completed by the wrapper or aborted by the watchdog.
  typedef enum logic {
    RES_OK   = 1'b0,
    RES_FAIL = 1'b1
  } arb_res_e;

endpackage

// File: rtl/wrapper_arbiter_rr_priority_pick.sv
// Round-robin priority pick: first set request scanning ptr, ptr+1, ... wrapping
// at NREQ-1. Purely combinational.
module rr_priority_pick
  import wrapper_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] w
);

  localparam int PW = $clog2(NREQ);
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

  logic [PW-1:0] idx;

  // Walk all NREQ positions starting at ptr; the first asserted request wins.
  always_comb begin
    valid = 1'b0;
    w     = '0;
    idx   = ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!valid && req[idx]) begin
        valid = 1'b1;
        w     = idx;
      end
      // Explicit wrap so non-power-of-two NREQ never indexes past the last requester.
      idx = (idx == LAST_IDX) ? '0 : idx + PW'(1);
    end
  end

endmodule

// File: rtl/wrapper_arbiter.sv
// Shares one engine wrapper among NREQ requesters: round-robin grant, operand
// latch, one-cycle start pulse, then waits for done or a watchdog timeout and
// returns ack or err to the winner.
//
// Handshake: req[i] is a level request. The arbiter answers with gnt[i], held
// from START through DONE; the service ends with exactly one single-cycle pulse
// on ack[i] (wrapper done) or err[i] (watchdog). Dropping req[i] while granted
// does not cancel the service. Toward the wrapper, wr_start is a one-cycle
// pulse, wr_din is stable from START through DONE, and wr_done is only
// observed in WAIT (level or pulse both work).
module wrapper_arbiter
  import wrapper_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         ack,
  output logic [NREQ-1:0]         err,
  output logic                    wr_start,
  output logic [DW-1:0]           wr_din,
  input  logic                    wr_done,
  output logic                    busy,
  output logic [1:0]              dbg_state_o,
  output logic [$clog2(NREQ)-1:0] dbg_ptr_o
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  arb_state_e    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] w_q, w_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] din_q, din_d;
  arb_res_e      res_q, res_d;

  logic          pick_valid;
  logic [PW-1:0] pick_w;

  rr_priority_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .w     (pick_w)
  );

  // State and datapath registers; reset wins over any service in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      w_q     <= '0;
      cnt_q   <= '0;
      din_q   <= '0;
      res_q   <= RES_OK;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      res_q   <= res_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, pulse in START, watch done/timeout in WAIT.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        // wr_done is deliberately not looked at here: a stale done is dropped.
        if (pick_valid) begin
          w_d     = pick_w;
          din_d   = req_data[pick_w*DW +: DW];
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Done is tested first so it wins over a simultaneous timeout.
        if (wr_done) begin
          res_d   = RES_OK;
          state_d = ST_DONE;
        end else if (cnt_q == LAST_CNT) begin
          res_d   = RES_FAIL;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        // Next search starts just after the winner, which gives the fairness bound.
        ptr_d   = (w_q == LAST_IDX) ? '0 : w_q + PW'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from registered state only; no path from req or wr_done.
  always_comb begin
    gnt         = '0;
    ack         = '0;
    err         = '0;
    wr_start    = 1'b0;
    busy        = (state_q != ST_IDLE);
    wr_din      = din_q;
    dbg_state_o = state_q;
    dbg_ptr_o   = ptr_q;
    if (state_q != ST_IDLE) begin
      gnt = ONE_HOT0 << w_q;
    end
    if (state_q == ST_START) begin
      wr_start = 1'b1;
    end
    if (state_q == ST_DONE) begin
      if (res_q == RES_OK) begin
        ack = ONE_HOT0 << w_q;
      end else begin
        err = ONE_HOT0 << w_q;
      end
    end
  end

endmodule

// File: tb/tb_wrapper_arbiter.sv
// Directed bench for wrapper_arbiter (NREQ=4, DW=16, TIMEOUT=8).
module tb_wrapper_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int TO   = 8;

  logic             clk;
  logic             rst;
  logic [NREQ-1:0]  req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  ack;
  logic [NREQ-1:0]  err;
  logic             wr_start;
  logic [DW-1:0]    wr_din;
  logic             wr_done;
  logic             busy;
  logic [1:0]       dbg_state;
  logic [1:0]       dbg_ptr;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  bit mon_en = 1'b0;

  wrapper_arbiter #(
    .NREQ    (NREQ),
    .DW      (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .ack         (ack),
    .err         (err),
    .wr_start    (wr_start),
    .wr_din      (wr_din),
    .wr_done     (wr_done),
    .busy        (busy),
    .dbg_state_o (dbg_state),
    .dbg_ptr_o   (dbg_ptr)
  );

  // Clock and global time limit.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count start pulses as seen by the wrapper.
  always @(posedge clk) begin
    if (wr_start === 1'b1) start_cnt++;
  end

  // Every cycle: ack/err never together and never for a non-granted index.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ack_err_excl", 32'(ack & err), 32'd0);
      chk("ack_err_gnt", 32'((ack | err) & ~gnt), 32'd0);
    end
  end

  // One service from IDLE: d>0 means wr_done sampled in the d-th WAIT cycle,
  // d==0 means no done at all (watchdog fires after TO WAIT cycles).
  task automatic run_service(input int exp_w, input int d, input logic [15:0] exp_din,
                             input int exp_ptr, input bit mid_change);
    int s0;
    s0 = start_cnt;
    tick();
    chk("st_start", 32'(dbg_state), 32'd1);
    chk("gnt_start", 32'(gnt), 32'(1 << exp_w));
    chk("wr_start_hi", 32'(wr_start), 32'd1);
    chk("busy_start", 32'(busy), 32'd1);
    chk("wr_din_start", 32'(wr_din), 32'(exp_din));
    if (mid_change) begin
      req = '0;
      req_data = {4{16'h5555}};
    end
    tick();
    chk("st_wait", 32'(dbg_state), 32'd2);
    chk("wr_start_lo", 32'(wr_start), 32'd0);
    if (d > 0) begin
      repeat (d - 1) tick();
      chk("st_wait_pre_done", 32'(dbg_state), 32'd2);
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
      chk("ack_pulse", 32'(ack), 32'(1 << exp_w));
      chk("err_quiet", 32'(err), 32'd0);
    end else begin
      repeat (TO - 1) tick();
      chk("st_wait_last", 32'(dbg_state), 32'd2);
      tick();
      chk("err_pulse", 32'(err), 32'(1 << exp_w));
      chk("ack_quiet", 32'(ack), 32'd0);
    end
    chk("st_done", 32'(dbg_state), 32'd3);
    chk("gnt_done", 32'(gnt), 32'(1 << exp_w));
    chk("wr_din_hold", 32'(wr_din), 32'(exp_din));
    tick();
    chk("st_idle", 32'(dbg_state), 32'd0);
    chk("gnt_drop", 32'(gnt), 32'd0);
    chk("ack_one_cycle", 32'(ack | err), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("ptr_next", 32'(dbg_ptr), 32'(exp_ptr));
    chk("one_start", 32'(start_cnt - s0), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"}, 32'(dbg_state), 32'd0);
    chk({tag, "_ptr"}, 32'(dbg_ptr), 32'd0);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_start"}, 32'(wr_start), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_din"}, 32'(wr_din), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    req_data = '0;
    wr_done = 1'b0;
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    // 1: single requester 2, done sampled in the 5th WAIT cycle.
    req = 4'b0100;
    req_data[2*DW +: DW] = 16'h1234;
    run_service(2, 5, 16'h1234, 3, 1'b1);

    // 2: all requesting from ptr=0, order 0,1,2,3,0 with no extra idle gap.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("reset2");
    req = 4'b1111;
    req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    run_service(0, 3, 16'h1111, 1, 1'b0);
    run_service(1, 3, 16'h2222, 2, 1'b0);
    run_service(2, 3, 16'h3333, 3, 1'b0);
    run_service(3, 3, 16'h4444, 0, 1'b0);
    run_service(0, 3, 16'h1111, 1, 1'b0);

    // 3: watchdog on requester 1, then requester 0 is served.
    req = 4'b0011;
    run_service(1, 0, 16'h2222, 2, 1'b0);
    run_service(0, 2, 16'h1111, 1, 1'b0);

    // 4: done in the cnt==TIMEOUT-1 cycle gives ack, not err.
    req = 4'b1000;
    run_service(3, TO, 16'h4444, 0, 1'b0);
    req = '0;

    // 5: reset during WAIT, stale done afterwards, then requester 1 served.
    req = 4'b0100;
    tick();
    chk("t5_start", 32'(dbg_state), 32'd1);
    req = '0;
    tick();
    tick();
    chk("t5_wait", 32'(dbg_state), 32'd2);
    rst = 1'b1;
    tick();
    check_all_zero("t5_rst");
    rst = 1'b0;
    wr_done = 1'b1;
    tick();
    chk("t5_stale_state", 32'(dbg_state), 32'd0);
    chk("t5_stale_ack", 32'(ack), 32'd0);
    chk("t5_stale_busy", 32'(busy), 32'd0);
    tick();
    chk("t5_stale_state2", 32'(dbg_state), 32'd0);
    wr_done = 1'b0;
    req = 4'b0010;
    req_data[1*DW +: DW] = 16'h00A1;
    run_service(1, 2, 16'h00A1, 2, 1'b0);
    req = '0;

    // 6: requester 0 drops req and changes data mid-service; done in IDLE ignored.
    req = 4'b0001;
    req_data[0 +: DW] = 16'hBEEF;
    run_service(0, 4, 16'hBEEF, 1, 1'b1);
    wr_done = 1'b1;
    tick();
    tick();
    chk("t6_idle_state", 32'(dbg_state), 32'd0);
    chk("t6_idle_ack", 32'(ack), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    chk("t6_idle_din", 32'(wr_din), 32'h0000BEEF);
    wr_done = 1'b0;
    tick();

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
